// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter sequencer and the Generic_counter it
// drives: default counter width, default command FIFO depth and the 2-bit
// sequencer state encoding.
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_DEPTH = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// ---------------------------------------------------------------------------
// counter_sequencer_if
// Command channel into the sequencer.
//   cmd_valid  producer has a (start, stop) command
//   cmd_ready  sequencer FIFO can take it
//   cmd_start  first count value
//   cmd_stop   last count value (inclusive)
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. The producer keeps valid/start/stop stable until
// that edge; ready may change freely and does not depend on valid.
// ---------------------------------------------------------------------------
interface counter_sequencer_if #(
  parameter int WIDTH = counter_pkg::DEF_WIDTH
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_stop;

  modport master (output cmd_valid, output cmd_start, output cmd_stop,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_start, input  cmd_stop,
                  output cmd_ready);
endinterface

// File: rtl/Generic_counter.sv
// ---------------------------------------------------------------------------
// Generic_counter
// Loadable up-counter, modulo 2^WIDTH. Load wins over enable.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high (clears the count)
//   cnt_in   load value
//   load     load cnt_in on the next edge
//   enable   increment on the next edge
//   cnt_out  registered count
// ---------------------------------------------------------------------------
module Generic_counter import counter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (load)   r_cnt <= cnt_in;
    else if (enable) r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_out = r_cnt;

endmodule

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding packed commands. Show-ahead: o_data is the head
// entry whenever o_empty is low. Push and pop in the same cycle are both
// performed. No bypass: data written at edge N is visible at edge N+1.
// Ports:
//   clk, rst     clock, synchronous active-low reset (empties the FIFO)
//   i_push       write i_data (ignored when full)
//   i_data       entry to write
//   i_pop        discard head entry (ignored when empty)
//   o_data       head entry
//   o_full       DEPTH entries held
//   o_empty      no entries held
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop  & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
// Control stage in front of Generic_counter. Queues (start, stop) commands
// and runs them one at a time: load start, count up until the fed-back
// cnt_out equals stop (wrapping modulo 2^WIDTH), then pulse done.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   cmd        command channel (slave side of counter_sequencer_if)
//   pause      freeze the count while running
//   abort      drop the active command and go idle (no done)
//   cnt_out    registered count from the counter
//   cnt_in     load value to the counter (0 when idle)
//   load       counter load strobe
//   enable     counter increment enable
//   busy       a command is being loaded, run or completed
//   done       one-cycle pulse when a command completes
//   dbg_state  current FSM state
// ---------------------------------------------------------------------------
module counter_sequencer import counter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  counter_sequencer_if.slave cmd,
  input  logic              pause,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_out,
  output logic [WIDTH-1:0]  cnt_in,
  output logic              load,
  output logic              enable,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_start;
  logic [WIDTH-1:0]   r_stop;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_match;
  logic [2*WIDTH-1:0] w_head;

  assign cmd.cmd_ready = rst & ~w_full;
  assign w_push        = cmd.cmd_valid & cmd.cmd_ready;

  cmd_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({cmd.cmd_start, cmd.cmd_stop}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_match = (cnt_out == r_stop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_start <= '0;
      r_stop  <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) {r_start, r_stop} <= w_head;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    load   = 1'b0;
    enable = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_next = ST_LOAD;
          w_pop  = 1'b1;
        end
      end
      ST_LOAD: begin
        load   = 1'b1;
        w_next = ST_RUN;
      end
      ST_RUN: begin
        // Stop incrementing on the match cycle so the counter rests on stop.
        enable = ~pause & ~w_match;
        if (w_match) w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        // Chain straight into the next queued command without an IDLE cycle.
        if (!w_empty) begin
          w_next = ST_LOAD;
          w_pop  = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Abort overrides every transition; the queued commands stay put.
    if (abort) begin
      w_next = ST_IDLE;
      w_pop  = 1'b0;
      enable = 1'b0;
      done   = 1'b0;
    end
    // Outputs are quiet for the whole time reset is held.
    if (!rst) begin
      w_pop  = 1'b0;
      load   = 1'b0;
      enable = 1'b0;
      done   = 1'b0;
    end
  end

  assign busy      = rst & (r_state != ST_IDLE);
  assign cnt_in    = (!rst || r_state == ST_IDLE) ? '0 : r_start;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  import counter_pkg::*;

  localparam int W = 5;
  localparam logic [W-1:0] MASK = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         pause;
  logic         abort;
  logic [W-1:0] cnt_out;
  logic [W-1:0] cnt_in;
  logic         load;
  logic         enable;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  int total;
  int bad;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  counter_sequencer_if #(.WIDTH(W)) cmd_if ();

  counter_sequencer #(.WIDTH(W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .pause     (pause),
    .abort     (abort),
    .cnt_out   (cnt_out),
    .cnt_in    (cnt_in),
    .load      (load),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  Generic_counter #(.WIDTH(W)) u_cnt (
    .clk     (clk),
    .rst     (!rst),
    .cnt_in  (cnt_in),
    .load    (load),
    .enable  (enable),
    .cnt_out (cnt_out)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (load) begin
        if (exp_q.size() == 0) check("load_without_cmd", 1, 0);
        else begin
          mon_e = exp_q[0];
          check("sb_load_cnt_in", int'(cnt_in), int'(mon_e[2*W-1:W]));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) check("done_without_cmd", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("sb_done_cnt_out", int'(cnt_out), int'(mon_e[W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_cmd(input logic [W-1:0] s, input logic [W-1:0] e);
    bit ok;
    ok = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_start = s;
    cmd_if.cmd_stop  = e;
    for (int k = 0; k < 50; k++) begin
      if (cmd_if.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check("push_timeout", 0, 1);
      cmd_if.cmd_valid = 1'b0;
    end else begin
      exp_q.push_back({s, e});
      tick();
      cmd_if.cmd_valid = 1'b0;
    end
  endtask

  // Wait (sampling at negedge) until the counter shows v during a run.
  task automatic wait_cnt(input logic [W-1:0] v);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy && !load && cnt_out == v) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_cnt_reached", int'(found), 1);
  endtask

  // Full run of one command into an idle sequencer, tracing every count.
  task automatic run_cmd(input logic [W-1:0] s, input logic [W-1:0] e);
    logic [W-1:0] v;
    logic [W-1:0] d;
    int lat;
    bit got;
    push_cmd(s, e);
    @(negedge clk);
    check("no_bypass_busy", int'(busy), 0);
    @(negedge clk);
    check("load_strobe", int'(load), 1);
    check("load_cnt_in", int'(cnt_in), int'(s));
    v   = s;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = i;
        break;
      end
      check("run_cnt_out", int'(cnt_out), int'(v));
      check("run_enable", int'(enable), int'(v != e));
      v = v + 1'b1;
    end
    d = (e - s) & MASK;
    check("done_seen", int'(got), 1);
    check("done_latency", lat, int'(d) + 1);
    @(negedge clk);
    check("after_done_busy", int'(busy), 0);
    check("after_done_flag", int'(done), 0);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int  nd;
    bit  gap;
    bit  hit;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_start = 5'd1;
    cmd_if.cmd_stop  = 5'd2;

    // 1: reset with a command offered
    repeat (3) begin
      @(negedge clk);
      check("rst_cmd_ready", int'(cmd_if.cmd_ready), 0);
      check("rst_load", int'(load), 0);
      check("rst_enable", int'(enable), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cnt_in", int'(cnt_in), 0);
    end
    cmd_if.cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_ready", int'(cmd_if.cmd_ready), 1);
      check("post_rst_state", int'(dbg_state), int'(ST_IDLE));
    end

    // 2: basic run
    tick();
    run_cmd(5'd3, 5'd7);

    // 3: wrap-around and start==stop
    tick();
    run_cmd(5'd30, 5'd1);
    tick();
    run_cmd(5'd9, 5'd9);

    // 4: back-to-back commands, FIFO full
    tick();
    push_cmd(5'd0, 5'd2);
    push_cmd(5'd5, 5'd6);
    push_cmd(5'd10, 5'd11);
    @(negedge clk);
    check("full_cmd_ready", int'(cmd_if.cmd_ready), 0);
    nd  = 0;
    gap = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (!busy && nd > 0 && nd < 3) gap = 1'b1;
      if (nd == 3) begin
        hit = 1'b1;
        break;
      end
    end
    check("b2b_three_done", int'(hit), 1);
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("b2b_done_count", nd, 3);
    check("b2b_no_idle_gap", int'(gap), 0);

    // 5: pause then abort, queued command runs afterwards
    tick();
    push_cmd(5'd0, 5'd10);
    push_cmd(5'd1, 5'd2);
    wait_cnt(5'd4);
    pause = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("pause_hold_cnt", int'(cnt_out), 4);
      check("pause_enable", int'(enable), 0);
    end
    pause = 1'b0;
    @(negedge clk);
    check("pause_resume_cnt", int'(cnt_out), 5);
    wait_cnt(5'd6);
    abort = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_no_done", int'(done), 0);
    check("abort_state", int'(dbg_state), int'(ST_IDLE));
    abort = 1'b0;
    @(negedge clk);
    check("requeue_load", int'(load), 1);
    check("requeue_cnt_in", int'(cnt_in), 1);
    hit = 1'b0;
    nd  = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        hit = 1'b1;
        nd  = i;
        break;
      end
    end
    check("requeue_done_seen", int'(hit), 1);
    check("requeue_done_latency", nd, 2);

    // 6: reset in the middle of a run with a command queued
    tick();
    push_cmd(5'd0, 5'd10);
    push_cmd(5'd4, 5'd4);
    wait_cnt(5'd5);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", int'(cmd_if.cmd_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_load", int'(load), 0);
    check("midrst_enable", int'(enable), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_cnt_in", int'(cnt_in), 0);
    check("midrst_cnt_out", int'(cnt_out), 0);
    check("midrst_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_fifo_empty_busy", int'(busy), 0);
    end
    tick();
    run_cmd(5'd2, 5'd3);

    repeat (3) @(negedge clk);
    check("sb_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
